instruction_fetch_unit: RTL

Initiator side of the instruction-memory interface for the pipelined RISC-V core. It owns the program counter and drives the byte address to the combinational, little-endian instruction memory. It captures the returned 32-bit word into the IF/ID pipeline register. It also handles stall, branch redirect/flush and halt detection, and reports a sticky misaligned-target error.

---
 rtl/instruction_fetch_unit.sv | 135 +++++++++++++
 1 files changed

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: owns the PC, drives the instruction-memory address and
// fills the IF/ID register, with stall, redirect/flush, halt and misaligned-target handling.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_RUN   | fetching; PC advances by 4 each unstalled cycle
// S_HALT  | halt word fetched or PC left memory; a redirect can resume
// S_ERROR | misaligned redirect seen; only reset leaves this state
module instruction_fetch_unit #(
  parameter logic [63:0] RESET_PC  = 64'd0,
  parameter int          MEM_BYTES = 132,
  parameter logic [31:0] NOP_INST  = 32'h00000013,
  parameter logic [31:0] HALT_INST = 32'h00000063
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instruction,
  output logic [63:0] Inst_Address,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [63:0] branch_target,
  output logic [63:0] IF_ID_PC,
  output logic [31:0] IF_ID_Instruction,
  output logic        IF_ID_valid,
  output logic        halted,
  output logic        misaligned
);

  localparam logic [63:0] LAST_ADDR = 64'(MEM_BYTES - 4);

  typedef enum logic [1:0] {S_RUN, S_HALT, S_ERROR} state_t;

  state_t      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [63:0] ifid_pc_q, ifid_pc_d;
  logic [31:0] ifid_inst_q, ifid_inst_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic        halted_q, halted_d;
  logic        misaligned_q, misaligned_d;
  logic        target_ok;

  assign target_ok = (branch_target[1:0] == 2'b00);

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_inst_d  = ifid_inst_q;
    ifid_valid_d = ifid_valid_q;
    misaligned_d = misaligned_q;

    case (state_q)
      S_RUN: begin
        if (branch_taken) begin
          ifid_pc_d    = 64'd0;
          ifid_inst_d  = NOP_INST;
          ifid_valid_d = 1'b0;
          if (target_ok) begin
            pc_d = branch_target;
          end else begin
            misaligned_d = 1'b1;
            state_d      = S_ERROR;
          end
        end else if (stall) begin
          // hold everything
        end else if (pc_q > LAST_ADDR) begin
          // never capture a word read from outside memory
          ifid_pc_d    = 64'd0;
          ifid_inst_d  = NOP_INST;
          ifid_valid_d = 1'b0;
          state_d      = S_HALT;
        end else begin
          ifid_pc_d    = pc_q;
          ifid_inst_d  = Instruction;
          ifid_valid_d = 1'b1;
          if (Instruction == HALT_INST) begin
            state_d = S_HALT;
          end else begin
            pc_d = pc_q + 64'd4;
          end
        end
      end
      S_HALT: begin
        ifid_pc_d    = 64'd0;
        ifid_inst_d  = NOP_INST;
        ifid_valid_d = 1'b0;
        // an older in-flight branch may still override the halt
        if (branch_taken) begin
          if (target_ok) begin
            pc_d    = branch_target;
            state_d = S_RUN;
          end else begin
            misaligned_d = 1'b1;
            state_d      = S_ERROR;
          end
        end
      end
      default: begin
        ifid_pc_d    = 64'd0;
        ifid_inst_d  = NOP_INST;
        ifid_valid_d = 1'b0;
      end
    endcase

    halted_d = (state_d != S_RUN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_RUN;
      pc_q         <= RESET_PC;
      ifid_pc_q    <= 64'd0;
      ifid_inst_q  <= NOP_INST;
      ifid_valid_q <= 1'b0;
      halted_q     <= 1'b0;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_inst_q  <= ifid_inst_d;
      ifid_valid_q <= ifid_valid_d;
      halted_q     <= halted_d;
      misaligned_q <= misaligned_d;
    end
  end

  assign Inst_Address      = pc_q;
  assign IF_ID_PC          = ifid_pc_q;
  assign IF_ID_Instruction = ifid_inst_q;
  assign IF_ID_valid       = ifid_valid_q;
  assign halted            = halted_q;
  assign misaligned        = misaligned_q;

endmodule
